disp_fetch_ctrl: RTL and testbench
==================================

# disp_fetch_ctrl

VRAM fetch controller for the display circuit. It sits between the display register block (DISPADDR, DISPON, RESOL) and the AXI master read-address channel that feeds the pixel FIFO. Once per frame it issues fixed-length AXI read bursts covering the whole frame buffer. Each burst is throttled so that its data always fits in the FIFO.

## Interface
Parameters:
- BURST_LEN, 64: beats per AXI read burst; 32-bit beats, one pixel per beat.
- FIFO_DEPTH, 1024: pixel FIFO capacity in words.
- MAX_OUTSTANDING, 4: maximum accepted-but-incomplete bursts.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARST  in  1  asynchronous, active-high reset.
- DISPON  in  1  display enable from DISPCTRL.
- RESOL  in  2  00 VGA, 01 XGA, 10 SXGA; 11 treated as VGA.
- DISPADDR  in  32  frame buffer base byte address.
- FRAME_START  in  1  one-cycle pulse at start of frame fetch window (ACLK domain).
- FIFO_WRCNT  in  11  words currently held in pixel FIFO.
- ARADDR  out  32  burst start byte address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARVALID  out  1  read-address valid.
- ARREADY  in  1  read-address ready.
- RVALID, RREADY, RLAST  in  1 each  read-data channel, monitored only.
- BUSY  out  1  high from frame accept until FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse when the last burst of a frame completes.
- OVERRUN  out  1  one-cycle pulse when FRAME_START arrives while BUSY.

## Operation
- States: IDLE, REQ, WAIT_HS, DRAIN.
- IDLE: on FRAME_START && DISPON, latch DISPADDR into the address register. Load the remaining-burst counter with pixels/BURST_LEN: VGA 4800, XGA 12288, SXGA 20480 (15-bit counter). Set BUSY and go to REQ.
- REQ: issue a request when all of the following hold:
  - DISPON is high;
  - outstanding < MAX_OUTSTANDING;
  - FIFO_WRCNT + (outstanding+1)*BURST_LEN <= FIFO_DEPTH.
  - Issuing means: set ARVALID and go to WAIT_HS.
- REQ with remaining==0, or with DISPON low: go to DRAIN.
- WAIT_HS: hold ARVALID/ARADDR stable until ARREADY. On handshake:
  - ARVALID drops;
  - ARADDR += BURST_LEN*4, mod 2^32;
  - remaining−1, outstanding+1;
  - return to REQ.
- ARVALID is never withdrawn before handshake, even if DISPON falls.
- Outstanding counter (3 bits): decrements on RVALID&&RREADY&&RLAST. Simultaneous increment and decrement leaves it unchanged.
- DRAIN: when outstanding==0, pulse FRAME_DONE, clear BUSY, go to IDLE.
- FRAME_START while BUSY: pulse OVERRUN; frame state and counters are unaffected.
- FRAME_START in IDLE with DISPON low: ignored, no flag.
- DISPADDR and RESOL changes after accept have no effect until the next frame.

## Timing
- Reset values:
  - ARVALID 0, ARADDR 0, ARLEN BURST_LEN-1;
  - BUSY 0, FRAME_DONE 0, OVERRUN 0;
  - state IDLE, all counters 0.
- Reset mid-frame aborts immediately. ARVALID drops asynchronously and outstanding is cleared.
- All outputs are registered.
- FRAME_START sampled at edge E0: BUSY high after E0. ARVALID high after E1 if credit allows.
- Handshake at edge Ea: ARVALID low after Ea. The next ARVALID rises no earlier than after Ea+1, so at most one request every 2 cycles.
- Credit is evaluated in REQ using FIFO_WRCNT and outstanding as sampled that cycle.
- Final RLAST sampled at edge Eb with outstanding==1: state enters DRAIN's exit, so FRAME_DONE is high for the cycle after Eb+1 and BUSY falls together with it.
- OVERRUN is high for exactly the cycle after the offending edge.

## Test plan
- VGA, DISPADDR=0x2012C000, ARREADY always 1, FIFO_WRCNT=0, RLAST returned 10 cycles after each AR:
  - exactly 4800 ARs, ARLEN=63;
  - first ARADDR 0x2012C000, last 0x2025 7F00 (base+0x12BF00);
  - one FRAME_DONE, BUSY low afterwards.
- Credit: FIFO_WRCNT=961, outstanding 0 → no ARVALID. Drop FIFO_WRCNT to 960 → ARVALID asserts two edges later.
- No RLAST returned, ARREADY=1 → exactly 4 handshakes, then ARVALID stays low. One RLAST → fifth AR issued.
- DISPON falls while ARVALID=1 and ARREADY=0:
  - ARVALID and ARADDR hold until ARREADY=1;
  - no further ARs;
  - FRAME_DONE after outstanding bursts complete.
- FRAME_START pulsed mid-frame → OVERRUN single-cycle pulse; total AR count still 4800.
- ARST asserted with ARVALID=1 and outstanding=3 → ARVALID/BUSY 0 immediately. After release, next FRAME_START (XGA) yields 12288 ARs from the new DISPADDR.

Source files
------------

// File: rtl/disp_fetch_ctrl_if.sv
// rtl/disp_fetch_ctrl_if.sv - AXI read-address channel plus monitored read-data handshake for the display fetch path
interface disp_fetch_ctrl_if;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;

  modport master (
    output ARADDR, ARLEN, ARVALID,
    input  ARREADY, RVALID, RREADY, RLAST
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID,
    output ARREADY, RVALID, RREADY, RLAST
  );
endinterface

// File: rtl/disp_fetch_ctrl.sv
// rtl/disp_fetch_ctrl.sv - per-frame VRAM burst fetch controller with FIFO-credit throttling
module disp_fetch_ctrl #(
  parameter int BURST_LEN       = 64,
  parameter int FIFO_DEPTH      = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               ACLK,
  input  logic               ARST,
  input  logic               DISPON,
  input  logic [1:0]         RESOL,
  input  logic [31:0]        DISPADDR,
  input  logic               FRAME_START,
  input  logic [10:0]        FIFO_WRCNT,
  disp_fetch_ctrl_if.master  axi,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic               OVERRUN
);

  localparam logic [14:0] VGA_BURSTS   = 15'((640 * 480) / BURST_LEN);
  localparam logic [14:0] XGA_BURSTS   = 15'((1024 * 768) / BURST_LEN);
  localparam logic [14:0] SXGA_BURSTS  = 15'((1280 * 1024) / BURST_LEN);
  localparam logic [31:0] ADDR_STEP    = 32'(BURST_LEN * 4);
  localparam logic [7:0]  AR_LEN       = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_LEN_U  = 32'(BURST_LEN);
  localparam logic [31:0] FIFO_DEPTH_U = 32'(FIFO_DEPTH);
  localparam logic [31:0] MAX_OUT_U    = 32'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_HS,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [14:0] remaining_q, remaining_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        arvalid_q, arvalid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;

  logic        ar_hs;
  logic        r_done;
  logic        credit_ok;
  logic [31:0] credit_need;
  logic [14:0] frame_bursts;

  assign ar_hs  = arvalid_q && axi.ARREADY;
  assign r_done = axi.RVALID && axi.RREADY && axi.RLAST;

  // Reserve FIFO room for every burst already in flight plus the one about to be requested.
  assign credit_need = 32'(FIFO_WRCNT) + (32'(outstanding_q) + 32'd1) * BURST_LEN_U;
  assign credit_ok   = (32'(outstanding_q) < MAX_OUT_U) && (credit_need <= FIFO_DEPTH_U);

  always_comb begin
    frame_bursts = VGA_BURSTS;
    case (RESOL)
      2'b01:   frame_bursts = XGA_BURSTS;
      2'b10:   frame_bursts = SXGA_BURSTS;
      default: frame_bursts = VGA_BURSTS;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs && !r_done) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (r_done && !ar_hs && outstanding_q != 3'd0) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    arvalid_d    = arvalid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = FRAME_START && busy_q;

    case (state_q)
      S_IDLE: begin
        if (FRAME_START && DISPON) begin
          addr_d      = DISPADDR;
          remaining_d = frame_bursts;
          busy_d      = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (remaining_q == 15'd0 || !DISPON) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          arvalid_d = 1'b1;
          state_d   = S_WAIT_HS;
        end
      end
      // ARVALID stays up here regardless of DISPON until the slave takes the address.
      S_WAIT_HS: begin
        if (axi.ARREADY) begin
          arvalid_d   = 1'b0;
          addr_d      = addr_q + ADDR_STEP;
          remaining_d = remaining_q - 15'd1;
          state_d     = S_REQ;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == 3'd0) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q       <= S_IDLE;
      addr_q        <= 32'd0;
      remaining_q   <= 15'd0;
      outstanding_q <= 3'd0;
      arvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      arvalid_q     <= arvalid_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = AR_LEN;
  assign axi.ARVALID = arvalid_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_disp_fetch_ctrl.sv
// tb/tb_disp_fetch_ctrl.sv - randomized self-checking bench for disp_fetch_ctrl
`timescale 1ns/1ps
module tb_disp_fetch_ctrl;
  localparam int BL   = 64;
  localparam int DEPTH = 1024;
  localparam int MAXO = 4;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b0;
  logic        DISPON = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [1:0]  RESOL = 2'd0;
  logic [31:0] DISPADDR = 32'd0;
  logic [10:0] FIFO_WRCNT = 11'd0;
  logic        BUSY, FRAME_DONE, OVERRUN;

  disp_fetch_ctrl_if axi ();

  disp_fetch_ctrl #(
    .BURST_LEN(BL),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .ACLK(ACLK),
    .ARST(ARST),
    .DISPON(DISPON),
    .RESOL(RESOL),
    .DISPADDR(DISPADDR),
    .FRAME_START(FRAME_START),
    .FIFO_WRCNT(FIFO_WRCNT),
    .axi(axi),
    .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE),
    .OVERRUN(OVERRUN)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int hs_cnt = 0, fd_cnt = 0, ov_cnt = 0, out_model = 0;
  int fd_edge = 0, last_rl_edge = 0;
  logic [31:0] exp_base = 32'd0, first_addr = 32'd0, last_addr = 32'd0;
  bit hs_pend = 1'b0;
  int rq[$];
  bit resp_free = 1'b1;
  int resp_credit = 0;
  int lat_min = 10, lat_max = 10;
  bit rnd_ready = 1'b0, rnd_wr = 1'b0;
  bit prev_hold = 1'b0, prev_av = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int prev_out = 0, prev_wr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #2;
  endtask

  function automatic int frame_bursts(input logic [1:0] res);
    case (res)
      2'd1:    return (1024 * 768) / BL;
      2'd2:    return (1280 * 1024) / BL;
      default: return (640 * 480) / BL;
    endcase
  endfunction

  // Observer: every event seen here takes effect at the next rising edge.
  initial forever begin
    int out_pre;
    @(negedge ACLK);
    if (ARST) begin
      prev_hold = 1'b0;
      prev_av   = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("ar_hold_valid", {31'd0, axi.ARVALID}, 32'd1);
        chk("ar_hold_addr", axi.ARADDR, prev_addr);
      end
      if (axi.ARVALID && !prev_av) begin
        chk("credit_outstanding", {31'd0, prev_out < MAXO}, 32'd1);
        chk("credit_fifo", {31'd0, (prev_wr + (prev_out + 1) * BL) <= DEPTH}, 32'd1);
      end
      out_pre = out_model;
      if (axi.ARVALID && axi.ARREADY) begin
        chk("araddr", axi.ARADDR, exp_base + 32'(hs_cnt) * 32'(BL * 4));
        chk("arlen", {24'd0, axi.ARLEN}, 32'(BL - 1));
        chk("outstanding_limit", {31'd0, out_model < MAXO}, 32'd1);
        if (hs_cnt == 0) first_addr = axi.ARADDR;
        last_addr = axi.ARADDR;
        hs_cnt++;
        hs_pend = 1'b1;
        out_model++;
      end
      if (axi.RVALID && axi.RREADY && axi.RLAST) begin
        out_model--;
        last_rl_edge = edge_n + 1;
      end
      if (FRAME_DONE) begin
        fd_cnt++;
        fd_edge = edge_n;
        chk("busy_falls_with_done", {31'd0, BUSY}, 32'd0);
      end
      if (OVERRUN) ov_cnt++;
      prev_hold = axi.ARVALID && !axi.ARREADY;
      prev_addr = axi.ARADDR;
      prev_av   = axi.ARVALID;
      prev_out  = out_pre;
      prev_wr   = int'(FIFO_WRCNT);
    end
  end

  // Memory model: returns one RLAST beat per accepted burst, in order, after a latency.
  initial forever begin
    int due;
    @(posedge ACLK);
    edge_n++;
    #1;
    if (hs_pend) begin
      due = edge_n + int'($urandom_range(lat_max, lat_min)) - 1;
      if (rq.size() > 0 && due < rq[$]) due = rq[$];
      rq.push_back(due);
      hs_pend = 1'b0;
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    if (!ARST && rq.size() > 0 && rq[0] <= edge_n && (resp_free || resp_credit > 0)) begin
      void'(rq.pop_front());
      axi.RVALID = 1'b1;
      axi.RLAST  = 1'b1;
      if (!resp_free) resp_credit--;
    end
  end

  task automatic start_frame(input logic [1:0] res, input logic [31:0] base);
    RESOL = res;
    DISPADDR = base;
    DISPON = 1'b1;
    exp_base = base;
    hs_cnt = 0;
    fd_cnt = 0;
    ov_cnt = 0;
    FRAME_START = 1'b1;
    step(1);
    FRAME_START = 1'b0;
    chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < bound) begin
      if (rnd_ready) axi.ARREADY = ($urandom_range(3, 0) != 0);
      if (rnd_wr) FIFO_WRCNT = 11'($urandom_range(960, 0));
      step(1);
      n++;
    end
    chk("frame_done_seen", {31'd0, fd_cnt != 0}, 32'd1);
  endtask

  task automatic wait_hs(input int target, input int bound);
    int n;
    n = 0;
    while (hs_cnt < target && n < bound) begin
      step(1);
      n++;
    end
    chk("hs_reached", {31'd0, hs_cnt >= target}, 32'd1);
  endtask

  initial begin
    logic [31:0] held, base;
    int snap, n;
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b0;
    axi.RREADY = 1'b1;
    axi.RLAST = 1'b0;
    #1 ARST = 1'b1;
    step(3);
    chk("rst_arvalid", {31'd0, axi.ARVALID}, 32'd0);
    chk("rst_araddr", axi.ARADDR, 32'd0);
    chk("rst_arlen", {24'd0, axi.ARLEN}, 32'd63);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, FRAME_DONE}, 32'd0);
    chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    ARST = 1'b0;
    step(2);

    // FRAME_START with display disabled is ignored without a flag
    FRAME_START = 1'b1;
    step(1);
    FRAME_START = 1'b0;
    chk("ignored_busy", {31'd0, BUSY}, 32'd0);
    chk("ignored_overrun", {31'd0, OVERRUN}, 32'd0);
    step(3);
    chk("ignored_arvalid", {31'd0, axi.ARVALID}, 32'd0);

    // Full VGA frame, ARREADY always high, with a mid-frame FRAME_START
    axi.ARREADY = 1'b1;
    FIFO_WRCNT = 11'd0;
    start_frame(2'd0, 32'h2012_C000);
    step(1);
    chk("arvalid_after_e1", {31'd0, axi.ARVALID}, 32'd1);
    DISPADDR = 32'hDEAD_0000;
    RESOL = 2'd2;
    step(300);
    FRAME_START = 1'b1;
    step(1);
    FRAME_START = 1'b0;
    chk("overrun_pulse", {31'd0, OVERRUN}, 32'd1);
    chk("overrun_busy_kept", {31'd0, BUSY}, 32'd1);
    step(1);
    chk("overrun_single", {31'd0, OVERRUN}, 32'd0);
    wait_done(30000);
    chk("vga_ar_count", hs_cnt, frame_bursts(2'd0));
    chk("vga_first_addr", first_addr, 32'h2012_C000);
    chk("vga_last_addr", last_addr, 32'h2025_7F00);
    chk("vga_done_timing", fd_edge, last_rl_edge + 1);
    chk("vga_busy_low", {31'd0, BUSY}, 32'd0);
    step(5);
    chk("vga_done_count", fd_cnt, 32'd1);
    chk("vga_overrun_count", ov_cnt, 32'd1);

    // Credit gating, outstanding limit, then reset mid-frame
    axi.ARREADY = 1'b0;
    FIFO_WRCNT = 11'd961;
    start_frame(2'd1, 32'h0804_0000);
    step(20);
    chk("credit_block", {31'd0, axi.ARVALID}, 32'd0);
    FIFO_WRCNT = 11'd960;
    step(2);
    chk("credit_release", {31'd0, axi.ARVALID}, 32'd1);
    FIFO_WRCNT = 11'd0;
    resp_free = 1'b0;
    resp_credit = 0;
    axi.ARREADY = 1'b1;
    step(40);
    chk("stall_hs_count", hs_cnt, 32'd4);
    chk("stall_arvalid", {31'd0, axi.ARVALID}, 32'd0);
    resp_credit = 1;
    wait_hs(5, 30);
    axi.ARREADY = 1'b0;
    step(6);
    chk("fifth_hs_count", hs_cnt, 32'd5);
    chk("full_again_arvalid", {31'd0, axi.ARVALID}, 32'd0);
    resp_credit = 1;
    step(6);
    chk("held_arvalid", {31'd0, axi.ARVALID}, 32'd1);
    #1 ARST = 1'b1;
    #1;
    chk("async_rst_arvalid", {31'd0, axi.ARVALID}, 32'd0);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    rq.delete();
    out_model = 0;
    hs_pend = 1'b0;
    resp_free = 1'b1;
    resp_credit = 0;
    step(2);
    ARST = 1'b0;
    step(2);

    // XGA frame after reset: random ARREADY, FIFO level and latency, address wraps
    rnd_ready = 1'b1;
    rnd_wr = 1'b1;
    lat_min = 4;
    lat_max = 14;
    base = 32'hFFE0_0000 + ($urandom_range(255, 0) << 8);
    start_frame(2'd1, base);
    wait_done(60000);
    rnd_ready = 1'b0;
    rnd_wr = 1'b0;
    chk("xga_ar_count", hs_cnt, frame_bursts(2'd1));
    chk("xga_first_addr", first_addr, base);
    chk("xga_busy_low", {31'd0, BUSY}, 32'd0);

    // DISPON falls while an address is pending
    axi.ARREADY = 1'b1;
    FIFO_WRCNT = 11'd0;
    lat_min = 10;
    lat_max = 10;
    start_frame(2'd2, 32'h1000_0000);
    wait_hs(6, 100);
    axi.ARREADY = 1'b0;
    n = 0;
    while (!axi.ARVALID && n < 50) begin
      step(1);
      n++;
    end
    held = axi.ARADDR;
    chk("dispon_pending_addr", held, 32'h1000_0000 + 32'(hs_cnt) * 32'(BL * 4));
    DISPON = 1'b0;
    step(5);
    chk("dispon_hold_valid", {31'd0, axi.ARVALID}, 32'd1);
    chk("dispon_hold_addr", axi.ARADDR, held);
    axi.ARREADY = 1'b1;
    step(2);
    snap = hs_cnt;
    chk("dispon_last_accepted", last_addr, held);
    step(30);
    chk("dispon_no_more_ar", hs_cnt, snap);
    wait_done(200);
    chk("dispon_busy_low", {31'd0, BUSY}, 32'd0);
    chk("dispon_done_timing", fd_edge, last_rl_edge + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
